// File: rtl/iir_pkg.sv
// Shared helpers for the IIR signal chain: width calculations and the
// rounding offset used by power-of-two averaging.
package iir_pkg;

   // Counter width for a block of up to 2^lmax samples; never zero wide.
   function automatic int cnt_w(input int lmax);
      return (lmax > 0) ? lmax : 1;
   endfunction

   function automatic int sel_w(input int lmax);
      return (lmax > 0) ? $clog2(lmax + 1) : 1;
   endfunction

   // Half an LSB of the shifted result, for round-half-up.
   function automatic logic [31:0] rnd_ofs(input int r);
      return (r == 0) ? 32'd0 : (32'd1 << (r - 1));
   endfunction

endpackage

// File: rtl/iir_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module iir_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         valid,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
   logic [PW:0]   count;
   logic          empty, do_push, do_pop;

   always_comb begin
      empty   = (count == '0);
      full    = (count == (PW + 1)'(DEPTH));
      valid   = !empty;
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      rd_nxt  = rd_ptr + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_nxt;
         if (do_push && !do_pop)      count <= count + (PW + 1)'(1);
         else if (do_pop && !do_push) count <= count - (PW + 1)'(1);
         // Head follows the next stored word; when the last word leaves while a
         // new one arrives, the memory write is not visible yet, so bypass it.
         if (do_pop) begin
            if (count > (PW + 1)'(1)) head <= mem[rd_nxt];
            else if (do_push)         head <= push_data;
         end else if (do_push && empty) begin
            head <= push_data;
         end
      end
   end

endmodule

// File: rtl/iir_decim.sv
// Power-of-two boxcar decimator behind the IIR filter: averages 2^r samples
// with round-half-up and queues results on a valid/ready stream.
module iir_decim
   import iir_pkg::*;
#(
   parameter int DW        = 10,
   parameter int LOG2R_MAX = 4,
   parameter int DEPTH     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic signed [DW-1:0]                 in,
   input  logic        [$clog2(LOG2R_MAX+1)-1:0] log2r,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic signed [DW-1:0]                 out,
   output logic                                 ovf,
   input  logic                                 clr_ovf
);
   localparam int AW = DW + LOG2R_MAX;
   localparam int CW = cnt_w(LOG2R_MAX);
   localparam int RW = $clog2(LOG2R_MAX + 1);

   typedef logic signed [DW-1:0] sample_t;
   typedef logic signed [AW-1:0] acc_t;

   acc_t          acc, sum, rnd, shifted;
   sample_t       res;
   logic [CW-1:0] cnt, last_cnt;
   logic [RW-1:0] r_cur, r_lim, r_eff;
   logic          last, push, pop, drop, full;

   always_comb begin
      r_lim    = (log2r > RW'(LOG2R_MAX)) ? RW'(LOG2R_MAX) : log2r;
      // The first sample of a block already uses the ratio it latches.
      r_eff    = (cnt == '0) ? r_lim : r_cur;
      last_cnt = CW'((32'd1 << r_eff) - 32'd1);
      last     = (cnt == last_cnt);
      sum      = acc + acc_t'(in);
      rnd      = sum + acc_t'(rnd_ofs(int'(r_eff)));
      shifted  = rnd >>> r_eff;
      res      = shifted[DW-1:0];
      push     = en && last;
      pop      = out_valid && out_ready;
      drop     = push && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         cnt   <= '0;
         r_cur <= '0;
         ovf   <= 1'b0;
      end else begin
         if (en) begin
            if (cnt == '0) r_cur <= r_lim;
            if (last) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CW'(1);
            end
         end
         if (drop)         ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end
   end

   iir_fifo #(
      .W     (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (res),
      .pop       (pop),
      .head      (out),
      .valid     (out_valid),
      .full      (full)
   );

endmodule
